// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine that masters the picorv32 native memory bus.
// Each word is one read transaction followed by one write transaction, with a one-cycle gap after each.
module mem_copy_dma #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    localparam int          TO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [31:0]      buf_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             valid_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic [31:0]      rd_addr_d;
    logic [31:0]      wr_addr_d;
    logic [LEN_W-1:0] idx_d;
    logic [TO_W-1:0]  to_cnt_d;
    logic             to_expire;

    // Address sums wrap naturally at 2^32.
    always_comb begin
        rd_addr_d = src_q + (32'(idx_q) << 2);
        wr_addr_d = dst_q + (32'(idx_q) << 2);
        idx_d     = idx_q + LEN_W'(1);
        to_cnt_d  = to_cnt_q + TO_W'(1);
        to_expire = (to_cnt_q == TO_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            to_cnt_q <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= 4'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q <= src_addr & WORD_MASK;
                        dst_q <= dst_addr & WORD_MASK;
                        len_q <= len;
                        idx_q <= '0;
                        err_q <= 1'b0;
                        if (len == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_RD;
                            busy_q   <= 1'b1;
                            valid_q  <= 1'b1;
                            wstrb_q  <= 4'h0;
                            addr_q   <= src_addr & WORD_MASK;
                            to_cnt_q <= '0;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        buf_q   <= mem_rdata;
                        valid_q <= 1'b0;
                        state_q <= S_RD_GAP;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (to_expire) begin
                            valid_q <= 1'b0;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RD_GAP: begin
                    state_q  <= S_WR;
                    valid_q  <= 1'b1;
                    wstrb_q  <= 4'hF;
                    addr_q   <= wr_addr_d;
                    wdata_q  <= buf_q;
                    to_cnt_q <= '0;
                end
                S_WR: begin
                    if (mem_ready) begin
                        idx_q   <= idx_d;
                        valid_q <= 1'b0;
                        state_q <= S_WR_GAP;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (to_expire) begin
                            valid_q <= 1'b0;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_WR_GAP: begin
                    if (idx_q == len_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        state_q  <= S_RD;
                        valid_q  <= 1'b1;
                        wstrb_q  <= 4'h0;
                        addr_q   <= rd_addr_d;
                        to_cnt_q <= '0;
                    end
                end
                S_FIN: begin
                    // A start seen here is dropped on purpose; only IDLE accepts requests.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_valid = valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: a 1-cycle-ack RAM responder with a transaction log,
// exercised with copy, zero-length, wrap, timeout, start-while-busy and reset cases.
module tb_mem_copy_dma;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, err;
    logic             mem_valid, mem_instr;
    logic             mem_ready = 1'b0;
    logic [31:0]      mem_addr, mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata = '0;

    logic             ack_en = 1'b1;
    logic             poke_en = 1'b0;
    logic [9:0]       poke_idx = '0;
    logic [31:0]      poke_data = '0;
    logic [31:0]      ram [1024];
    logic [31:0]      log_addr [64];
    logic             log_wr [64];
    int               log_n = 0;
    int               valid_cycles = 0;
    int               busy_cycles = 0;
    int               done_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;

    mem_copy_dma #(.LEN_W(LEN_W), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM responder: acks one cycle after it sees mem_valid and logs every transaction.
    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_data;
        if (ack_en && mem_valid && !mem_ready) begin
            mem_ready <= 1'b1;
            if (mem_wstrb == 4'hF) ram[mem_addr[11:2]] <= mem_wdata;
            else                   mem_rdata <= ram[mem_addr[11:2]];
            if (log_n < 64) begin
                log_addr[log_n] <= mem_addr;
                log_wr[log_n]   <= (mem_wstrb == 4'hF);
            end
            log_n <= log_n + 1;
        end else begin
            mem_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mem_valid) valid_cycles <= valid_cycles + 1;
        if (busy)      busy_cycles  <= busy_cycles + 1;
        if (done)      done_cnt     <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        poke_en   = 1'b1;
        poke_idx  = addr[11:2];
        poke_data = data;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int k, ln0, dn0, vc0, bc0;
        logic [31:0] exp_a [8];
        logic        found;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_valid", mem_valid, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_val("rst_wstrb", mem_wstrb, 0);
        check_val("rst_instr", mem_instr, 0);
        resetn = 1'b1;
        tick();

        // Four-word copy 0x100 -> 0x200
        poke(32'h100, 32'd11);
        poke(32'h104, 32'd22);
        poke(32'h108, 32'd33);
        poke(32'h10C, 32'd44);
        ln0 = log_n;
        dn0 = done_cnt;
        kick(32'h100, 32'h200, 4);
        check_val("t1_busy", busy, 1);
        check_val("t1_valid", mem_valid, 1);
        check_val("t1_rd_addr", mem_addr, 32'h100);
        check_val("t1_rd_strb", mem_wstrb, 4'h0);
        wait_done(100, k);
        check_val("t1_latency", k, 24);
        check_val("t1_err", err, 0);
        check_val("t1_busy_fin", busy, 0);
        kick(32'h3F0, 32'h3E0, 1);
        check_val("t1_fin_start_valid", mem_valid, 0);
        check_val("t1_fin_start_busy", busy, 0);
        repeat (4) tick();
        check_val("t1_ntx", log_n - ln0, 8);
        check_val("t1_done_cnt", done_cnt - dn0, 1);
        exp_a = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208, 32'h10C, 32'h20C};
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("t1_tx%0d_addr", i), log_addr[ln0 + i], exp_a[i]);
            check_val($sformatf("t1_tx%0d_wr", i), log_wr[ln0 + i], (i % 2));
        end
        check_val("t1_ram200", ram[10'h080], 32'd11);
        check_val("t1_ram204", ram[10'h081], 32'd22);
        check_val("t1_ram208", ram[10'h082], 32'd33);
        check_val("t1_ram20C", ram[10'h083], 32'd44);

        // Zero length
        vc0 = valid_cycles;
        bc0 = busy_cycles;
        kick(32'h100, 32'h200, 0);
        check_val("t2_done", done, 1);
        check_val("t2_busy", busy, 0);
        tick();
        check_val("t2_done_drop", done, 0);
        repeat (3) tick();
        check_val("t2_no_valid", valid_cycles - vc0, 0);
        check_val("t2_no_busy", busy_cycles - bc0, 0);

        // Unaligned inputs, source wraps past the top of the address space
        poke(32'hFFFFFFF8, 32'hA0A0_0001);
        poke(32'hFFFFFFFC, 32'hA0A0_0002);
        poke(32'h00000000, 32'hA0A0_0003);
        ln0 = log_n;
        kick(32'hFFFFFFFB, 32'h13, 3);
        wait_done(100, k);
        check_val("t3_latency", k, 18);
        exp_a = '{32'hFFFFFFF8, 32'h10, 32'hFFFFFFFC, 32'h14, 32'h0, 32'h18, 32'h0, 32'h0};
        check_val("t3_ntx", log_n - ln0, 6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("t3_tx%0d_addr", i), log_addr[ln0 + i], exp_a[i]);
        end
        check_val("t3_ram10", ram[10'h004], 32'hA0A0_0001);
        check_val("t3_ram18", ram[10'h006], 32'hA0A0_0003);

        // Timeout: responder silent
        ack_en = 1'b0;
        tick();
        ln0 = log_n;
        vc0 = valid_cycles;
        kick(32'h300, 32'h380, 2);
        wait_done(50, k);
        check_val("t4_latency", k, 8);
        check_val("t4_err", err, 1);
        check_val("t4_valid_low", mem_valid, 0);
        tick();
        check_val("t4_valid_cycles", valid_cycles - vc0, 8);
        check_val("t4_err_sticky", err, 1);
        ack_en = 1'b1;
        tick();
        kick(32'h100, 32'h240, 1);
        check_val("t4_err_clear", err, 0);
        wait_done(50, k);
        check_val("t4_retry_latency", k, 6);
        check_val("t4_retry_err", err, 0);
        check_val("t4_retry_ram", ram[10'h090], 32'd11);

        // Second start while busy must not disturb the running copy
        tick();
        ln0 = log_n;
        kick(32'h100, 32'h280, 2);
        k = -1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 3) begin
                start    = 1'b1;
                src_addr = 32'h3F0;
                dst_addr = 32'h3E0;
                len      = 4;
            end
            tick();
            if (i == 3) start = 1'b0;
            if (done) begin
                k = i;
                break;
            end
        end
        check_val("t5_latency", k, 12);
        check_val("t5_ntx", log_n - ln0, 4);
        exp_a = '{32'h100, 32'h280, 32'h104, 32'h284, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t5_tx%0d_addr", i), log_addr[ln0 + i], exp_a[i]);
        end
        check_val("t5_ram280", ram[10'h0A0], 32'd11);
        check_val("t5_ram284", ram[10'h0A1], 32'd22);

        // Asynchronous reset while a write is on the bus
        tick();
        kick(32'h100, 32'h2C0, 4);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_valid && mem_wstrb == 4'hF) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_val("t6_found_wr", found, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_val("t6_valid_async", mem_valid, 0);
        check_val("t6_busy_async", busy, 0);
        check_val("t6_addr_async", mem_addr, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ln0 = log_n;
        vc0 = valid_cycles;
        repeat (20) tick();
        check_val("t6_no_tx", log_n - ln0, 0);
        check_val("t6_no_valid", valid_cycles - vc0, 0);
        check_val("t6_busy_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Bus initiator for the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Copies a block of 32-bit words from a source address to a destination address, one word at a time: a read transaction followed by a write transaction.
- Sits beside the CPU as a second master behind an external arbiter. It talks to the same RAM, UART and LED responders the CPU uses.

Parameters:
- LEN_W, 16, width of the word-count input and the internal word index.
- TIMEOUT, 1023, max cycles mem_valid may stay high without mem_ready before the transfer aborts with an error.

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a copy; sampled only in IDLE
- src_addr  input  32  source byte address; bits [1:0] ignored
- dst_addr  input  32  destination byte address; bits [1:0] ignored
- len  input  LEN_W  number of 32-bit words to copy
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse at completion or abort
- err  output  1  sticky timeout flag; cleared by next accepted start
- mem_valid  output  1  transaction request
- mem_instr  output  1  tied 0
- mem_ready  input  1  responder acknowledge
- mem_addr  output  32  word-aligned transaction address
- mem_wdata  output  32  write data
- mem_wstrb  output  4  4'h0 for reads, 4'hF for writes
- mem_rdata  input  32  read data, valid in the cycle mem_ready=1

Behaviour:
- Reset (async, resetn=0): state IDLE. busy=0, done=0, err=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, index=0, timeout counter=0. Takes effect immediately, even mid-transaction; mem_valid drops without waiting for mem_ready.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE:
  - On start=1, latch {src[31:2],2'b00}, {dst[31:2],2'b00} and len; clear err and index.
  - len==0 -> FIN; otherwise -> RD.
- RD:
  - mem_valid=1, mem_wstrb=0, mem_addr=src+4*index.
  - On mem_ready=1: capture mem_rdata into the data buffer and go to RD_GAP.
- RD_GAP: mem_valid=0 for exactly one cycle (bus turnaround), then -> WR.
- WR:
  - mem_valid=1, mem_wstrb=4'hF, mem_addr=dst+4*index, mem_wdata=buffer.
  - On mem_ready=1: index+1, then -> WR_GAP.
- WR_GAP: mem_valid=0 for one cycle. Then index==len -> FIN, else -> RD.
- FIN: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
- Handshake rules:
  - mem_addr, mem_wdata and mem_wstrb are registered and stay stable while mem_valid=1 until mem_ready is sampled high.
  - mem_valid deasserts in the cycle after the ready edge.
  - mem_ready while mem_valid=0 is ignored.
- Timing: with a responder that acks one cycle after valid, each word costs 6 cycles (RD 2, RD_GAP 1, WR 2, WR_GAP 1).
- Timeout:
  - A counter clears on entering RD or WR and increments each cycle mem_valid=1 && mem_ready=0.
  - When the counter reaches TIMEOUT, drop mem_valid, set err=1 and go to FIN. done still pulses.
- Address arithmetic: modulo 2^32; a wrap past 0xFFFFFFFC continues at 0x00000000. The index is LEN_W bits; len max is 2^LEN_W-1.
- start while busy=1 is ignored, and latched parameters are unchanged. start in the FIN cycle is also ignored.
- busy=1 in RD, RD_GAP, WR and WR_GAP.
- mem_instr=0 always.

Test Plan:
- Copy, 1-cycle-ack RAM model: RAM[0x100..0x10C]={11,22,33,44}, start with src=0x100, dst=0x200, len=4 -> RAM[0x200..0x20C]={11,22,33,44}. Exactly 8 transactions, alternating rd/wr. done pulses once, 24 cycles after start accepted, err=0.
- Zero length: len=0, start -> no mem_valid. done pulses the cycle after start, busy never rises.
- Unaligned inputs with wrap: src=0xFFFFFFFB, dst=0x13, len=3 -> reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; writes at 0x10, 0x14, 0x18.
- Timeout with TIMEOUT=8: responder never acks -> mem_valid high 8 cycles then low, err=1, done pulses. Next start with a good responder clears err.
- start while busy: second start with different src/dst mid-copy -> ignored. Original transfer completes at its original addresses.
- Reset mid-transfer: assert resetn=0 while mem_valid=1 in WR -> mem_valid=0 and busy=0 immediately (asynchronous). No further transactions after release until a new start.
